// File: rtl/apb_hub_pkg.sv
// Shared types and defaults for the APB debug hub: FSM states, response kinds
// and the default parameter values used by the hub and its decoder.
package apb_hub_pkg;

  localparam int DEF_ADDR_W    = 5;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_NUM_PORTS = 3;
  localparam int DEF_SEL_W     = 2;
  localparam int DEF_TIMEOUT   = 15;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } hub_state_e;

  localparam logic [1:0] OK          = 2'd0;
  localparam logic [1:0] DECODE_ERR  = 2'd1;
  localparam logic [1:0] TIMEOUT_ERR = 2'd2;
  localparam logic [1:0] SLAVE_ERR   = 2'd3;

endpackage

// File: rtl/apb_hub_decoder.sv
// Port-index decode: the top SEL_W address bits pick a downstream completer,
// and valid says whether that completer actually exists.
module apb_hub_decoder
  import apb_hub_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int SEL_W     = DEF_SEL_W,
  parameter int NUM_PORTS = DEF_NUM_PORTS
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [SEL_W-1:0]  idx,
  output logic              valid
);

  // The low address bits belong to the completer, not to the decode.
  logic unused_low_bits;

  assign idx             = addr[ADDR_W-1 -: SEL_W];
  assign valid           = (32'(idx) < NUM_PORTS);
  assign unused_low_bits = ^addr[ADDR_W-SEL_W-1:0];

endmodule

// File: rtl/apb_debug_hub.sv
// APB debug hub: bridges one upstream APB completer port onto NUM_PORTS
// downstream completers, with decode/timeout error reporting and counting.
module apb_debug_hub
  import apb_hub_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int SEL_W     = DEF_SEL_W,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                        PCLK,
  input  logic                        PRESET,
  input  logic                        PSEL,
  input  logic [ADDR_W-1:0]           PADDR,
  input  logic                        PENABLE,
  input  logic                        PWRITE,
  input  logic [DATA_W-1:0]           PWDATA,
  output logic [DATA_W-1:0]           PRDATA,
  output logic                        PREADY,
  output logic                        PSLVERR,
  output logic [NUM_PORTS-1:0]        M_PSEL,
  output logic [ADDR_W-SEL_W-1:0]     M_PADDR,
  output logic                        M_PENABLE,
  output logic                        M_PWRITE,
  output logic [DATA_W-1:0]           M_PWDATA,
  input  logic [NUM_PORTS*DATA_W-1:0] M_PRDATA,
  input  logic [NUM_PORTS-1:0]        M_PREADY,
  input  logic [NUM_PORTS-1:0]        M_PSLVERR,
  input  logic                        ERR_CLEAR,
  output logic [7:0]                  ERR_COUNT,
  output logic [ADDR_W-1:0]           LAST_ERR_ADDR
);

  hub_state_e            state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [SEL_W-1:0]      idx_q, idx_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;
  logic [NUM_PORTS-1:0]  m_psel_q, m_psel_d;
  logic                  m_penable_q, m_penable_d;
  logic [7:0]            err_count_q, err_count_d;
  logic [ADDR_W-1:0]     last_err_addr_q, last_err_addr_d;

  logic [SEL_W-1:0]      dec_idx;
  logic                  dec_valid;
  logic [DATA_W-1:0]     sel_rdata;
  logic                  sel_ready;
  logic                  sel_slverr;
  logic                  enter_err;

  apb_hub_decoder #(
    .ADDR_W   (ADDR_W),
    .SEL_W    (SEL_W),
    .NUM_PORTS(NUM_PORTS)
  ) u_decoder (
    .addr (PADDR),
    .idx  (dec_idx),
    .valid(dec_valid)
  );

  // Mux the response of whichever completer the latched index points at.
  always_comb begin
    sel_rdata  = '0;
    sel_ready  = 1'b0;
    sel_slverr = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (idx_q == SEL_W'(i)) begin
        sel_rdata  = M_PRDATA[i*DATA_W +: DATA_W];
        sel_ready  = M_PREADY[i];
        sel_slverr = M_PSLVERR[i];
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    write_d         = write_q;
    wdata_d         = wdata_q;
    idx_d           = idx_q;
    cnt_d           = cnt_q;
    rdata_d         = rdata_q;
    resp_d          = resp_q;
    err_count_d     = err_count_q;
    last_err_addr_d = last_err_addr_q;
    m_psel_d        = '0;

    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
          idx_d   = dec_idx;
          rdata_d = '0;
          if (dec_valid) begin
            state_d = SETUP;
            resp_d  = OK;
          end else begin
            state_d = DONE;
            resp_d  = DECODE_ERR;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = 8'd1;
      end
      ACCESS: begin
        if (sel_ready) begin
          state_d = DONE;
          cnt_d   = '0;
          rdata_d = write_q ? '0 : sel_rdata;
          resp_d  = sel_slverr ? SLAVE_ERR : OK;
        end else if (cnt_q == 8'(TIMEOUT)) begin
          state_d = DONE;
          cnt_d   = '0;
          rdata_d = '0;
          resp_d  = TIMEOUT_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Errors are booked on the edge that enters DONE, whether or not anyone is still listening.
    enter_err = (state_d == DONE) && (state_q != DONE) && (resp_d != OK);
    if (ERR_CLEAR) begin
      err_count_d = enter_err ? 8'd1 : 8'd0;
    end else if (enter_err && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
    if (enter_err) begin
      last_err_addr_d = addr_d;
    end

    if ((state_d == SETUP) || (state_d == ACCESS)) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        m_psel_d[i] = (idx_d == SEL_W'(i));
      end
    end
    m_penable_d = (state_d == ACCESS);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      write_q         <= 1'b0;
      wdata_q         <= '0;
      idx_q           <= '0;
      cnt_q           <= '0;
      rdata_q         <= '0;
      resp_q          <= OK;
      m_psel_q        <= '0;
      m_penable_q     <= 1'b0;
      err_count_q     <= '0;
      last_err_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      write_q         <= write_d;
      wdata_q         <= wdata_d;
      idx_q           <= idx_d;
      cnt_q           <= cnt_d;
      rdata_q         <= rdata_d;
      resp_q          <= resp_d;
      m_psel_q        <= m_psel_d;
      m_penable_q     <= m_penable_d;
      err_count_q     <= err_count_d;
      last_err_addr_q <= last_err_addr_d;
    end
  end

  // The upstream response is only visible while the requester is in its access phase.
  assign PREADY        = (state_q == DONE) && PSEL && PENABLE;
  assign PRDATA        = PREADY ? rdata_q : '0;
  assign PSLVERR       = PREADY && (resp_q != OK);
  assign M_PSEL        = m_psel_q;
  assign M_PENABLE     = m_penable_q;
  assign M_PADDR       = addr_q[ADDR_W-SEL_W-1:0];
  assign M_PWRITE      = write_q;
  assign M_PWDATA      = wdata_q;
  assign ERR_COUNT     = err_count_q;
  assign LAST_ERR_ADDR = last_err_addr_q;

endmodule
